// File: rtl/uart_tx_slave.sv
// Memory-mapped 8N1 UART transmitter on the IO slave port.
// CPU writes land in a small TX FIFO that a bit-timed serializer drains onto uartTransmit.
module uart_tx_slave #(
    parameter int CLOCKS_PER_BIT = 16,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic        clock,
    input  logic        resetActiveHigh,
    input  logic [31:0] ioAxiWriteAddress,
    input  logic        ioAxiWriteValid,
    output logic        ioAxiWriteReady,
    input  logic [31:0] ioAxiWriteData,
    input  logic        ioAxiWriteValidData,
    output logic        ioAxiWriteReadyData,
    input  logic [31:0] ioAxiReadAddress,
    input  logic        ioAxiReadValid,
    output logic        ioAxiReadReady,
    output logic [31:0] ioAxiReadData,
    output logic        ioAxiReadValidData,
    input  logic        ioAxiReadReadyData,
    output logic        uartTransmit
);

    localparam int ADDR_W  = $clog2(FIFO_DEPTH);
    localparam int TIMER_W = $clog2(CLOCKS_PER_BIT);

    localparam logic [1:0] STATE_IDLE  = 2'd0;
    localparam logic [1:0] STATE_START = 2'd1;
    localparam logic [1:0] STATE_DATA  = 2'd2;
    localparam logic [1:0] STATE_STOP  = 2'd3;

    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(CLOCKS_PER_BIT - 1);

    localparam logic [1:0] REG_TXDATA = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;

    logic [1:0]         state;
    logic [TIMER_W-1:0] bitTimer;
    logic [2:0]         bitIndex;
    logic [7:0]         shiftReg;
    logic               txLine;

    logic [7:0]         fifoMem [FIFO_DEPTH];
    logic [ADDR_W:0]    writePtr;
    logic [ADDR_W:0]    readPtr;
    logic               fifoFull;
    logic               fifoEmpty;
    logic               overflow;

    logic               writeFire;
    logic               pushRequest;
    logic               pushAccepted;
    logic               popFifo;
    logic               bitDone;
    logic               busy;
    logic [31:0]        statusValue;
    logic [31:0]        readValue;
    logic               readValidReg;
    logic [31:0]        readDataReg;
    logic               unusedAddressBits;

    assign writeFire           = ioAxiWriteValid & ioAxiWriteValidData;
    assign ioAxiWriteReady     = writeFire;
    assign ioAxiWriteReadyData = writeFire;

    assign pushRequest = writeFire && (ioAxiWriteAddress[3:2] == REG_TXDATA);
    assign fifoEmpty   = (writePtr == readPtr);
    assign fifoFull    = (writePtr[ADDR_W] != readPtr[ADDR_W]) &&
                         (writePtr[ADDR_W-1:0] == readPtr[ADDR_W-1:0]);
    assign bitDone     = (bitTimer == TIMER_LAST);

    // Pops happen from IDLE or on the last stop-bit cycle, which keeps queued frames contiguous.
    assign popFifo      = !fifoEmpty && ((state == STATE_IDLE) || ((state == STATE_STOP) && bitDone));
    assign pushAccepted = pushRequest && (!fifoFull || popFifo);

    assign busy        = (state != STATE_IDLE) || !fifoEmpty;
    assign statusValue = {28'd0, overflow, busy, fifoEmpty, fifoFull};

    always_comb begin
        readValue = '0;
        if (ioAxiReadAddress[3:2] == REG_STATUS) begin
            readValue = statusValue;
        end
    end

    assign unusedAddressBits = ^{ioAxiWriteAddress[31:4], ioAxiWriteAddress[1:0],
                                 ioAxiWriteData[31:8], ioAxiReadAddress[31:4],
                                 ioAxiReadAddress[1:0]};

    // A push into a full FIFO during a pop overwrites the slot being read out this same edge.
    always_ff @(posedge clock) begin
        if (pushAccepted) begin
            fifoMem[writePtr[ADDR_W-1:0]] <= ioAxiWriteData[7:0];
        end
    end

    always_ff @(posedge clock or posedge resetActiveHigh) begin
        if (resetActiveHigh) begin
            writePtr <= '0;
            readPtr  <= '0;
        end else begin
            if (pushAccepted) begin
                writePtr <= writePtr + 1'b1;
            end
            if (popFifo) begin
                readPtr <= readPtr + 1'b1;
            end
        end
    end

    always_ff @(posedge clock or posedge resetActiveHigh) begin
        if (resetActiveHigh) begin
            overflow <= 1'b0;
        end else if (pushRequest && fifoFull && !popFifo) begin
            overflow <= 1'b1;
        end else if (writeFire && (ioAxiWriteAddress[3:2] == REG_STATUS) && ioAxiWriteData[3]) begin
            overflow <= 1'b0;
        end
    end

    always_ff @(posedge clock or posedge resetActiveHigh) begin
        if (resetActiveHigh) begin
            state    <= STATE_IDLE;
            bitTimer <= '0;
            bitIndex <= '0;
            shiftReg <= '0;
            txLine   <= 1'b1;
        end else begin
            case (state)
                STATE_IDLE: begin
                    if (popFifo) begin
                        shiftReg <= fifoMem[readPtr[ADDR_W-1:0]];
                        bitTimer <= '0;
                        txLine   <= 1'b0;
                        state    <= STATE_START;
                    end
                end
                STATE_START: begin
                    if (bitDone) begin
                        bitTimer <= '0;
                        bitIndex <= '0;
                        txLine   <= shiftReg[0];
                        state    <= STATE_DATA;
                    end else begin
                        bitTimer <= bitTimer + 1'b1;
                    end
                end
                STATE_DATA: begin
                    if (bitDone) begin
                        bitTimer <= '0;
                        if (bitIndex == 3'd7) begin
                            txLine <= 1'b1;
                            state  <= STATE_STOP;
                        end else begin
                            bitIndex <= bitIndex + 1'b1;
                            shiftReg <= {1'b0, shiftReg[7:1]};
                            txLine   <= shiftReg[1];
                        end
                    end else begin
                        bitTimer <= bitTimer + 1'b1;
                    end
                end
                STATE_STOP: begin
                    if (bitDone) begin
                        bitTimer <= '0;
                        if (popFifo) begin
                            shiftReg <= fifoMem[readPtr[ADDR_W-1:0]];
                            txLine   <= 1'b0;
                            state    <= STATE_START;
                        end else begin
                            txLine <= 1'b1;
                            state  <= STATE_IDLE;
                        end
                    end else begin
                        bitTimer <= bitTimer + 1'b1;
                    end
                end
                default: begin
                    txLine <= 1'b1;
                    state  <= STATE_IDLE;
                end
            endcase
        end
    end

    assign uartTransmit = txLine;

    always_ff @(posedge clock or posedge resetActiveHigh) begin
        if (resetActiveHigh) begin
            readValidReg <= 1'b0;
            readDataReg  <= '0;
        end else if (!readValidReg) begin
            if (ioAxiReadValid) begin
                readValidReg <= 1'b1;
                readDataReg  <= readValue;
            end
        end else if (ioAxiReadReadyData) begin
            readValidReg <= 1'b0;
        end
    end

    assign ioAxiReadReady     = !readValidReg;
    assign ioAxiReadValidData = readValidReg;
    assign ioAxiReadData      = readDataReg;

endmodule
